// File: rtl/display_pkg.sv
// display_pkg: screen constants, fixed-point split helper and scanner FSM states
package display_pkg;
  localparam int H_CENTER = 800;
  localparam int V_CENTER = 600;
  localparam int H_ACTIVE = 1600;
  localparam int V_ACTIVE = 1200;
  localparam int OFF_COL  = 1700;
  localparam int OFF_ROW  = 1300;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, PUBLISH} scan_state_e;
  function automatic logic [63:0] fx_int(input logic [63:0] v, input int unsigned w);
    return v >> (w / 2);
  endfunction
endpackage

// File: rtl/axis_project.sv
// axis_project: one-axis zoom shift, centring add and clip of a fixed-point coordinate
module axis_project #(
  parameter int WIDTH    = 32,
  parameter int OUT_BITS = 12,
  parameter int CENTER   = display_pkg::H_CENTER,
  parameter int ACTIVE   = display_pkg::H_ACTIVE,
  parameter int OFF      = display_pkg::OFF_COL
) (
  input  logic [WIDTH-1:0]    loc_i,
  input  logic [3:0]          shift_i,
  output logic [WIDTH/2:0]    sum_o,
  input  logic [WIDTH/2:0]    sum_i,
  output logic [OUT_BITS-1:0] value_o,
  output logic                clipped_o,
  output logic                in_active_o
);
  import display_pkg::*;
  localparam int H = WIDTH / 2;
  logic signed [H-1:0] ip, s;
  assign ip = H'(fx_int(64'(loc_i), WIDTH));
  assign s = ip >>> shift_i;
  // one extra bit keeps the centred sum from wrapping
  assign sum_o = {s[H-1], s} + (H + 1)'(CENTER);
  assign clipped_o = sum_i[H] | (|sum_i[H-1:OUT_BITS]);
  assign value_o = clipped_o ? OUT_BITS'(OFF) : sum_i[OUT_BITS-1:0];
  assign in_active_o = !clipped_o && sum_i[OUT_BITS-1:0] < OUT_BITS'(ACTIVE);
endmodule

// File: rtl/sprite_center_scanner.sv
// sprite_center_scanner: per-frame snapshot, pipelined conversion and double-buffered publish of sprite centres
module sprite_center_scanner #(
  parameter int SPRITES  = 9,
  parameter int WIDTH    = 32,
  parameter int COL_BITS = 12,
  parameter int ROW_BITS = 11,
  parameter int H_CENTER = display_pkg::H_CENTER,
  parameter int V_CENTER = display_pkg::V_CENTER,
  parameter int H_ACTIVE = display_pkg::H_ACTIVE,
  parameter int V_ACTIVE = display_pkg::V_ACTIVE,
  parameter int OFF_COL  = display_pkg::OFF_COL,
  parameter int OFF_ROW  = display_pkg::OFF_ROW
) (
  input  logic                                 clk,
  input  logic                                 rst_L,
  input  logic                                 start,
  input  logic [3:0]                           scale_shift,
  input  logic [SPRITES-1:0][1:0][WIDTH-1:0]   locations,
  output logic [SPRITES-1:0][COL_BITS-1:0]     cols,
  output logic [SPRITES-1:0][ROW_BITS-1:0]     rows,
  output logic [SPRITES-1:0]                   onscreen,
  output logic                                 busy,
  output logic                                 done
);
  import display_pkg::*;
  localparam int H  = WIDTH / 2;
  localparam int IW = SPRITES > 1 ? $clog2(SPRITES) : 1;
  scan_state_e state_q;
  logic [IW-1:0] idx_q, s1_idx_q;
  logic [SPRITES-1:0][1:0][WIDTH-1:0] loc_q;
  logic [3:0] shift_q;
  logic s1_vld_q;
  logic [H:0] x_sum, y_sum, s1_x_q, s1_y_q;
  logic [COL_BITS-1:0] col_v;
  logic [ROW_BITS-1:0] row_v;
  logic col_clip, row_clip, col_act, row_act;
  logic [SPRITES-1:0][COL_BITS-1:0] wb_col_q, wb_col_d;
  logic [SPRITES-1:0][ROW_BITS-1:0] wb_row_q, wb_row_d;
  logic [SPRITES-1:0] wb_on_q, wb_on_d;
  axis_project #(.WIDTH(WIDTH), .OUT_BITS(COL_BITS), .CENTER(H_CENTER), .ACTIVE(H_ACTIVE), .OFF(OFF_COL)) u_x (
    .loc_i(loc_q[idx_q][0]), .shift_i(shift_q), .sum_o(x_sum), .sum_i(s1_x_q),
    .value_o(col_v), .clipped_o(col_clip), .in_active_o(col_act)
  );
  axis_project #(.WIDTH(WIDTH), .OUT_BITS(ROW_BITS), .CENTER(V_CENTER), .ACTIVE(V_ACTIVE), .OFF(OFF_ROW)) u_y (
    .loc_i(loc_q[idx_q][1]), .shift_i(shift_q), .sum_o(y_sum), .sum_i(s1_y_q),
    .value_o(row_v), .clipped_o(row_clip), .in_active_o(row_act)
  );
  // stage 2 write; publish reads this so the last sprite is included without an extra cycle
  always_comb begin
    wb_col_d = wb_col_q;
    wb_row_d = wb_row_q;
    wb_on_d = wb_on_q;
    if (s1_vld_q) begin
      wb_col_d[s1_idx_q] = col_v;
      wb_row_d[s1_idx_q] = row_v;
      wb_on_d[s1_idx_q] = col_act & row_act & ~(col_clip | row_clip);
    end
  end
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= IDLE;
      idx_q <= '0;
      s1_idx_q <= '0;
      s1_vld_q <= 1'b0;
      s1_x_q <= '0;
      s1_y_q <= '0;
      loc_q <= '0;
      shift_q <= '0;
      wb_col_q <= '0;
      wb_row_q <= '0;
      wb_on_q <= '0;
      cols <= {SPRITES{COL_BITS'(OFF_COL)}};
      rows <= {SPRITES{ROW_BITS'(OFF_ROW)}};
      onscreen <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      s1_vld_q <= state_q == SCAN;
      s1_idx_q <= idx_q;
      s1_x_q <= x_sum;
      s1_y_q <= y_sum;
      wb_col_q <= wb_col_d;
      wb_row_q <= wb_row_d;
      wb_on_q <= wb_on_d;
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          loc_q <= locations;
          shift_q <= scale_shift;
          idx_q <= '0;
          busy <= 1'b1;
          state_q <= SCAN;
        end
        SCAN: begin
          idx_q <= idx_q == IW'(SPRITES - 1) ? '0 : idx_q + IW'(1);
          state_q <= idx_q == IW'(SPRITES - 1) ? DRAIN : SCAN;
        end
        DRAIN: begin
          cols <= wb_col_d;
          rows <= wb_row_d;
          onscreen <= wb_on_d;
          done <= 1'b1;
          busy <= 1'b0;
          state_q <= PUBLISH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
